// File: rtl/gps_acq_search_sched_pkg.sv
// Shared encodings and command payload for the GPS acquisition search sequencer.
package gps_acq_search_sched_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned BIN_W  = 5;
  localparam int unsigned CHIP_W = 11;

  localparam int unsigned DEF_BIN_STEP = 93957;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_SEARCH  = 3'd2;
  localparam logic [2:0] ST_CONFIRM = 3'd3;
  localparam logic [2:0] ST_TRACK   = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  // Sequencer -> Doppler bin generator command, one-hot in practice
  typedef struct packed {
    logic clear;
    logic load;
    logic step;
    logic recenter;
  } dop_cmd_t;

endpackage

// File: rtl/gps_acq_search_sched_bin_gen.sv
// Doppler bin generator: zig-zag carrier word around a latched centre using
// two running offsets, so no multiplier is needed.
module gps_doppler_bin_gen
  import gps_acq_search_sched_pkg::*;
#(
  parameter int unsigned FW       = 30,
  parameter int unsigned BIN_STEP = DEF_BIN_STEP
) (
  input  logic             mclk,
  input  logic             mclr,
  input  dop_cmd_t         cmd,
  input  logic [FW-1:0]    center_freq,
  output logic [FW-1:0]    carr_word,
  output logic [BIN_W-1:0] bin_idx
);

  logic [FW-1:0] centre;
  logic [FW-1:0] pos_off;
  logic [FW-1:0] neg_off;
  logic [FW-1:0] pos_nxt;
  logic [FW-1:0] neg_nxt;

  assign pos_nxt = pos_off + FW'(BIN_STEP);
  assign neg_nxt = neg_off + FW'(BIN_STEP);

  // Even current bin steps to an odd (positive) bin, odd steps to negative
  always_ff @(posedge mclk) begin
    if (!mclr || cmd.clear) begin
      centre    <= '0;
      pos_off   <= '0;
      neg_off   <= '0;
      carr_word <= '0;
      bin_idx   <= '0;
    end else if (cmd.load) begin
      centre    <= center_freq;
      pos_off   <= '0;
      neg_off   <= '0;
      carr_word <= center_freq;
      bin_idx   <= '0;
    end else if (cmd.step) begin
      bin_idx <= bin_idx + BIN_W'(1);
      if (!bin_idx[0]) begin
        pos_off   <= pos_nxt;
        carr_word <= centre + pos_nxt;
      end else begin
        neg_off   <= neg_nxt;
        carr_word <= centre - neg_nxt;
      end
    end else if (cmd.recenter) begin
      carr_word <= centre;
    end
  end

endmodule

// File: rtl/gps_acq_search_sched.sv
// Coarse acquisition sequencer for one GPS channel: Doppler/code sweep,
// M-of-N confirmation, hand-off to tracking and re-search on lock loss.
module gps_acq_search_sched
  import gps_acq_search_sched_pkg::*;
#(
  parameter int unsigned FW       = 30,
  parameter int unsigned NBINS    = 21,
  parameter int unsigned NCHIPS   = 2046,
  parameter int unsigned BIN_STEP = DEF_BIN_STEP,
  parameter int unsigned CONF_N   = 8,
  parameter int unsigned CONF_M   = 6
) (
  input  logic              mclk,
  input  logic              mclr,
  input  logic              start,
  input  logic              abort,
  input  logic              dwell_done,
  input  logic              above_thr,
  input  logic              lock_loss,
  input  logic [FW-1:0]     center_freq,
  output logic [FW-1:0]     carr_word,
  output logic              code_slip,
  output logic              code_reset,
  output logic              acq,
  output logic              busy,
  output logic              fail,
  output logic [BIN_W-1:0]  bin_idx,
  output logic [CHIP_W-1:0] chip_idx
);

  localparam int unsigned CNT_W = $clog2(CONF_N + 1);

  logic [ST_W-1:0]   state, state_n;
  logic [CHIP_W-1:0] chip_n;
  logic [CNT_W-1:0]  hits, hits_n, hits_nx;
  logic [CNT_W-1:0]  tries, tries_n, tries_nx;
  logic              slip_n, creset_n, adv;
  dop_cmd_t          cmd;

  assign hits_nx  = hits + CNT_W'(above_thr);
  assign tries_nx = tries + CNT_W'(1);

  gps_doppler_bin_gen #(
    .FW       (FW),
    .BIN_STEP (BIN_STEP)
  ) u_bin_gen (
    .mclk        (mclk),
    .mclr        (mclr),
    .cmd         (cmd),
    .center_freq (center_freq),
    .carr_word   (carr_word),
    .bin_idx     (bin_idx)
  );

  always_ff @(posedge mclk) begin
    if (!mclr) begin
      state      <= ST_IDLE;
      chip_idx   <= '0;
      hits       <= '0;
      tries      <= '0;
      code_slip  <= 1'b0;
      code_reset <= 1'b0;
      acq        <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      chip_idx   <= chip_n;
      hits       <= hits_n;
      tries      <= tries_n;
      code_slip  <= slip_n;
      code_reset <= creset_n;
      acq        <= (state_n == ST_TRACK);
      busy       <= (state_n == ST_SETTLE) || (state_n == ST_SEARCH) ||
                    (state_n == ST_CONFIRM);
      fail       <= (state_n == ST_FAIL);
    end
  end

  // Next state, counters and pulse requests; abort overrides everything
  always_comb begin
    state_n  = state;
    chip_n   = chip_idx;
    hits_n   = hits;
    tries_n  = tries;
    slip_n   = 1'b0;
    creset_n = 1'b0;
    adv      = 1'b0;
    cmd      = '0;

    case (state)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          cmd.load = 1'b1;
          chip_n   = '0;
          hits_n   = '0;
          tries_n  = '0;
          creset_n = 1'b1;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (dwell_done) state_n = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (dwell_done) begin
          if (above_thr) begin
            hits_n  = CNT_W'(1);
            tries_n = CNT_W'(1);
            state_n = ST_CONFIRM;
          end else begin
            adv = 1'b1;
          end
        end
      end
      ST_CONFIRM: begin
        if (dwell_done) begin
          hits_n  = hits_nx;
          tries_n = tries_nx;
          if (hits_nx >= CNT_W'(CONF_M)) state_n = ST_TRACK;
          else if (tries_nx == CNT_W'(CONF_N)) adv = 1'b1;
        end
      end
      ST_TRACK: begin
        if (lock_loss) begin
          chip_n   = '0;
          creset_n = 1'b1;
          state_n  = ST_SETTLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Next code phase, else next bin, else sweep exhausted
    if (adv) begin
      if (chip_idx != CHIP_W'(NCHIPS - 1)) begin
        slip_n  = 1'b1;
        chip_n  = chip_idx + CHIP_W'(1);
        state_n = ST_SEARCH;
      end else if (bin_idx != BIN_W'(NBINS - 1)) begin
        chip_n   = '0;
        cmd.step = 1'b1;
        creset_n = 1'b1;
        state_n  = ST_SETTLE;
      end else begin
        cmd.recenter = 1'b1;
        state_n      = ST_FAIL;
      end
    end

    if (abort) begin
      cmd       = '0;
      cmd.clear = 1'b1;
      chip_n    = '0;
      hits_n    = '0;
      tries_n   = '0;
      slip_n    = 1'b0;
      creset_n  = 1'b0;
      state_n   = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_gps_acq_search_sched.sv
// Randomized bench for gps_acq_search_sched against a behavioural reference
// model of the search/confirm/track rules, preceded by directed scenarios.
module tb_gps_acq_search_sched;

  localparam int unsigned FW     = 30;
  localparam int unsigned NBINS  = 3;
  localparam int unsigned NCHIPS = 4;
  localparam int unsigned STEP   = 100;
  localparam int unsigned CONF_N = 4;
  localparam int unsigned CONF_M = 3;

  localparam int M_IDLE = 0, M_SETTLE = 1, M_SEARCH = 2, M_CONFIRM = 3,
                 M_TRACK = 4, M_FAIL = 5;

  logic          mclk = 1'b0;
  logic          mclr, start, abort, dwell_done, above_thr, lock_loss;
  logic [FW-1:0] center_freq;
  logic [FW-1:0] carr_word;
  logic          code_slip, code_reset, acq, busy, fail;
  logic [4:0]    bin_idx;
  logic [10:0]   chip_idx;

  gps_acq_search_sched #(
    .FW(FW), .NBINS(NBINS), .NCHIPS(NCHIPS), .BIN_STEP(STEP),
    .CONF_N(CONF_N), .CONF_M(CONF_M)
  ) dut (
    .mclk(mclk), .mclr(mclr), .start(start), .abort(abort),
    .dwell_done(dwell_done), .above_thr(above_thr), .lock_loss(lock_loss),
    .center_freq(center_freq), .carr_word(carr_word), .code_slip(code_slip),
    .code_reset(code_reset), .acq(acq), .busy(busy), .fail(fail),
    .bin_idx(bin_idx), .chip_idx(chip_idx)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int            m_mode = M_IDLE;
  logic [FW-1:0] m_centre = '0;
  logic [FW-1:0] m_carr = '0;
  int            m_bin = 0, m_chip = 0, m_hits = 0, m_tries = 0;
  logic          m_slip = 0, m_creset = 0;

  logic [FW-1:0] cf_cur;
  logic          last_slip;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] carr_of(input logic [FW-1:0] c, input int k);
    logic [FW-1:0] off;
    if (k == 0) return c;
    if (k % 2 == 1) begin
      off = FW'((k + 1) / 2 * STEP);
      return c + off;
    end
    off = FW'(k / 2 * STEP);
    return c - off;
  endfunction

  task automatic model_clear();
    m_mode = M_IDLE; m_centre = '0; m_carr = '0;
    m_bin = 0; m_chip = 0; m_hits = 0; m_tries = 0;
  endtask

  task automatic model_advance();
    if (m_chip < NCHIPS - 1) begin
      m_slip = 1; m_chip++; m_mode = M_SEARCH;
    end else if (m_bin < NBINS - 1) begin
      m_chip = 0; m_bin++; m_carr = carr_of(m_centre, m_bin);
      m_creset = 1; m_mode = M_SETTLE;
    end else begin
      m_carr = m_centre; m_mode = M_FAIL;
    end
  endtask

  task automatic model_step(input logic r, a, s, d, h, l, input logic [FW-1:0] cf);
    m_slip = 0; m_creset = 0;
    if (!r || a) begin
      model_clear();
      return;
    end
    case (m_mode)
      M_IDLE, M_FAIL: if (s) begin
        m_centre = cf; m_bin = 0; m_chip = 0; m_carr = cf;
        m_hits = 0; m_tries = 0; m_creset = 1; m_mode = M_SETTLE;
      end
      M_SETTLE: if (d) m_mode = M_SEARCH;
      M_SEARCH: if (d) begin
        if (h) begin m_hits = 1; m_tries = 1; m_mode = M_CONFIRM; end
        else model_advance();
      end
      M_CONFIRM: if (d) begin
        m_tries++; m_hits += int'(h);
        if (m_hits >= CONF_M) m_mode = M_TRACK;
        else if (m_tries == CONF_N) model_advance();
      end
      M_TRACK: if (l) begin
        m_chip = 0; m_creset = 1; m_mode = M_SETTLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check_eq("carr_word", 32'(carr_word), 32'(m_carr));
    check_eq("code_slip", 32'(code_slip), 32'(m_slip));
    check_eq("code_reset", 32'(code_reset), 32'(m_creset));
    check_eq("acq", 32'(acq), 32'(m_mode == M_TRACK));
    check_eq("busy", 32'(busy),
             32'(m_mode == M_SETTLE || m_mode == M_SEARCH || m_mode == M_CONFIRM));
    check_eq("fail", 32'(fail), 32'(m_mode == M_FAIL));
    check_eq("bin_idx", 32'(bin_idx), 32'(m_bin));
    check_eq("chip_idx", 32'(chip_idx), 32'(m_chip));
  endtask

  // One clock: drive, advance model on the edge, compare 1 ns later
  task automatic tick(input logic r, a, s, d, h, l, input logic [FW-1:0] cf);
    mclr = r; abort = a; start = s; dwell_done = d; above_thr = h;
    lock_loss = l; center_freq = cf;
    @(posedge mclk);
    model_step(r, a, s, d, h, l, cf);
    #1;
    compare_all();
  endtask

  task automatic idle_tick();
    tick(1, 0, 0, 0, 0, 0, cf_cur);
  endtask

  task automatic do_start(input logic [FW-1:0] cf);
    cf_cur = cf;
    tick(1, 0, 1, 0, 0, 0, cf);
    idle_tick();
  endtask

  task automatic dwell(input logic h);
    tick(1, 0, 0, 1, h, 0, cf_cur);
    last_slip = code_slip;
    idle_tick();
  endtask

  initial begin
    cf_cur = FW'(1000);
    last_slip = 1'b0;

    // Reset and a full empty sweep ending in FAIL
    tick(0, 0, 0, 0, 0, 0, cf_cur);
    tick(0, 0, 0, 0, 0, 0, cf_cur);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_carr", 32'(carr_word), 0);
    do_start(FW'(1000));
    check_eq("t1_carr0", 32'(carr_word), 1000);
    for (int i = 0; i < 5; i++) dwell(0);
    check_eq("t1_carr1", 32'(carr_word), 1100);
    for (int i = 0; i < 5; i++) dwell(0);
    check_eq("t1_carr2", 32'(carr_word), 900);
    for (int i = 0; i < 5; i++) dwell(0);
    check_eq("t1_fail", 32'(fail), 1);
    check_eq("t1_carr_back", 32'(carr_word), 1000);

    // Restart from FAIL, hit at chip 2 of bin 1, confirm into TRACK
    do_start(FW'(1000));
    check_eq("t2_fail_clr", 32'(fail), 0);
    for (int i = 0; i < 8; i++) dwell(0);
    dwell(1);
    check_eq("t2_noslip", 32'(last_slip), 0);
    dwell(1);
    dwell(1);
    dwell(1);
    check_eq("t2_acq", 32'(acq), 1);
    check_eq("t2_carr", 32'(carr_word), 1100);
    check_eq("t2_chip", 32'(chip_idx), 2);

    // lock_loss wins over a simultaneous dwell_done in TRACK
    tick(1, 0, 0, 1, 1, 1, cf_cur);
    check_eq("t4_creset", 32'(code_reset), 1);
    check_eq("t4_acq", 32'(acq), 0);
    check_eq("t4_chip", 32'(chip_idx), 0);
    check_eq("t4_bin", 32'(bin_idx), 1);
    idle_tick();
    dwell(1);
    check_eq("t4_discard", 32'(busy), 1);
    dwell(1);

    // Confirm with hits 1,0,0,1 falls short and resumes search
    dwell(0);
    dwell(0);
    dwell(1);
    check_eq("t3_slip", 32'(last_slip), 1);
    check_eq("t3_chip", 32'(chip_idx), 1);
    check_eq("t3_acq", 32'(acq), 0);

    // abort beats dwell_done; start ignored while confirming
    tick(1, 1, 0, 1, 0, 0, cf_cur);
    check_eq("t5_slip", 32'(code_slip), 0);
    check_eq("t5_busy", 32'(busy), 0);
    do_start(FW'(1000));
    dwell(0);
    dwell(1);
    tick(1, 0, 1, 0, 0, 0, FW'(5));
    check_eq("t5_ign_creset", 32'(code_reset), 0);
    check_eq("t5_ign_carr", 32'(carr_word), 1000);

    // mclr mid-confirm, then frequency wrap at the top of the word
    tick(0, 0, 0, 0, 0, 0, cf_cur);
    check_eq("t6_rst_busy", 32'(busy), 0);
    do_start(FW'((64'd1 << FW) - 64'd50));
    for (int i = 0; i < 5; i++) dwell(0);
    check_eq("t6_wrap", 32'(carr_word), 50);
    dwell(0);
    dwell(1);
    dwell(1);
    check_eq("t6_not_yet", 32'(acq), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, a, s, d, h, l;
      logic [FW-1:0] cf;
      r = ($urandom_range(0, 599) != 0);
      a = ($urandom_range(0, 249) == 0);
      s = ($urandom_range(0, 14) == 0);
      d = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 9) < 5);
      l = (m_mode == M_TRACK) && ($urandom_range(0, 9) == 0);
      cf = ($urandom_range(0, 3) == 0) ? FW'(-$urandom_range(0, 250)) : FW'($urandom);
      tick(r, a, s, d, h, l, cf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
